serial_demux_1to8: RTL and testbench

- Receiving end of the team's 8:1 time-division mux link.
- The mux side drives one serial bit per valid cycle while its 3-bit select steps lane 0..7.
- This block routes each incoming bit to the matching lane register using an internal lane counter, and presents the assembled 8-bit word with a one-cycle valid strobe.
- Frame alignment comes from a sync input asserted with lane 0; the block flags misalignment.

---
 rtl/serial_mux_pkg.sv | 26 ++
 rtl/serial_demux_1to8_if.sv | 45 ++++
 rtl/lane_decoder_3to8.sv | 22 ++
 rtl/serial_demux_1to8.sv | 97 +++++++++
 tb/tb_serial_demux_1to8.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/serial_mux_pkg.sv
// ============================================================================
// serial_mux_pkg : lane constants, lane index type and lane-to-bit mapping
//                  shared by both ends of the 8:1 TDM link.
// Option macro   : SERIAL_DEMUX_MSB_FIRST_EN (first frame bit -> MSB)
// Revision       : 1.0
// ============================================================================
`default_nettype none

package serial_mux_pkg;

  localparam int MUX_LANES = 8;
  localparam int MUX_SEL_W = 3;

  typedef logic [MUX_SEL_W-1:0] lane_idx_t;

  function automatic lane_idx_t lane_to_bit(input lane_idx_t i_lane);
`ifdef SERIAL_DEMUX_MSB_FIRST_EN
    lane_to_bit = lane_idx_t'(MUX_LANES - 1) - i_lane;
`else
    lane_to_bit = i_lane;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_demux_1to8_if.sv
// ============================================================================
// serial_demux_1to8_if : serial input side and assembled-word output side
//                        of the 1:8 demux.
// Revision             : 1.0
// ============================================================================
`default_nettype none

interface serial_demux_1to8_if
  import serial_mux_pkg::*;
#(
  parameter int LANES = MUX_LANES,
  parameter int SEL_W = MUX_SEL_W
);

  logic             din;
  logic             din_valid;
  logic             sync;
  logic [LANES-1:0] dout;
  logic             dout_valid;
  logic [SEL_W-1:0] lane;
  logic             sync_err;

  modport master (
    output din,
    output din_valid,
    output sync,
    input  dout,
    input  dout_valid,
    input  lane,
    input  sync_err
  );

  modport slave (
    input  din,
    input  din_valid,
    input  sync,
    output dout,
    output dout_valid,
    output lane,
    output sync_err
  );

endinterface

`default_nettype wire

// File: rtl/lane_decoder_3to8.sv
// ============================================================================
// lane_decoder_3to8 : one-hot lane write enable, same AND-term decode as
//                     the transmit-side select.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module lane_decoder_3to8
  import serial_mux_pkg::*;
(
  input  wire lane_idx_t            i_lane,
  input  wire                       i_en,
  output logic [MUX_LANES-1:0]      o_we
);

  for (genvar g = 0; g < MUX_LANES; g++) begin : g_dec
    assign o_we[g] = i_en && (i_lane == lane_idx_t'(g));
  end

endmodule

`default_nettype wire

// File: rtl/serial_demux_1to8.sv
// ============================================================================
// serial_demux_1to8 : routes serial bits into lane registers, emits each
//                     completed 8-bit frame with a one-cycle valid strobe.
// Option macro      : SERIAL_DEMUX_MSB_FIRST_EN (via serial_mux_pkg)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module serial_demux_1to8
  import serial_mux_pkg::*;
#(
  parameter int LANES = MUX_LANES,
  parameter int SEL_W = MUX_SEL_W
)(
  input  wire                   clk,
  input  wire                   rst,
  serial_demux_1to8_if.slave    bus
);

  localparam logic [SEL_W-1:0] c_last_lane = SEL_W'(LANES - 1);

  logic [LANES-1:0] r_shadow;
  logic [LANES-1:0] r_dout;
  logic [SEL_W-1:0] r_lane;
  logic             r_dout_valid;
  logic             r_sync_err;

  logic             w_bit_wr;
  logic             w_last;
  logic [LANES-1:0] w_we;
  logic [LANES-1:0] w_asm;
  logic [LANES-1:0] w_frame;
  logic [LANES-1:0] w_sync_shadow;

  // A sync cycle restarts the frame, so it never takes the normal lane write.
  assign w_bit_wr = bus.din_valid && !bus.sync;
  assign w_last   = w_bit_wr && (r_lane == c_last_lane);

  lane_decoder_3to8 u_dec (
    .i_lane (lane_idx_t'(r_lane)),
    .i_en   (w_bit_wr),
    .o_we   (w_we)
  );

  always_comb begin
    w_asm = r_shadow;
    for (int i = 0; i < LANES; i++) begin
      if (w_we[i]) w_asm[i] = bus.din;
    end
  end

  // Reorder lane-indexed bits into output bit positions.
  always_comb begin
    w_frame = '0;
    for (int i = 0; i < LANES; i++) begin
      w_frame[lane_to_bit(lane_idx_t'(i))] = w_asm[i];
    end
  end

  always_comb begin
    w_sync_shadow    = '0;
    w_sync_shadow[0] = bus.din_valid && bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_dout       <= '0;
      r_lane       <= '0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
      if (bus.sync) begin
        r_shadow   <= w_sync_shadow;
        r_lane     <= bus.din_valid ? SEL_W'(1) : '0;
        r_sync_err <= (r_lane != '0);
      end else if (bus.din_valid) begin
        r_shadow <= w_asm;
        r_lane   <= r_lane + SEL_W'(1);
        if (w_last) begin
          r_dout       <= w_frame;
          r_dout_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.lane       = r_lane;
  assign bus.sync_err   = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_demux_1to8.sv
// ============================================================================
// tb_serial_demux_1to8 : directed vectors for serial_demux_1to8.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_serial_demux_1to8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  serial_demux_1to8_if u_if ();

  serial_demux_1to8 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected dout for a frame whose lane-k bit is v[k].
  function automatic logic [7:0] exp_word(input logic [7:0] v);
`ifdef SERIAL_DEMUX_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) exp_word[7-i] = v[i];
`else
    exp_word = v;
`endif
  endfunction

  task automatic send(input logic d, input logic v, input logic s);
    @(negedge clk);
    u_if.din = d; u_if.din_valid = v; u_if.sync = s;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic sync_first,
                            input logic gap, output int vcyc);
    for (int k = 0; k < 8; k++) begin
      send(v[k], 1'b1, sync_first && (k == 0));
      if (k < 7) begin
        chk("mid_frame_valid", u_if.dout_valid, 0);
      end else begin
        chk("frame_valid", u_if.dout_valid, 1);
        chk("frame_dout", u_if.dout, exp_word(v));
        chk("frame_lane", u_if.lane, 0);
        vcyc = cyc;
      end
      if (gap && k < 7) begin
        send(1'b0, 1'b0, 1'b0);
        chk("gap_lane", u_if.lane, k + 1);
      end
    end
  endtask

  initial begin
    int c1, c2, pulses;
    u_if.din = 1'b0; u_if.din_valid = 1'b0; u_if.sync = 1'b0;

    // 1: reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_dout", u_if.dout, 0);
    chk("rst_lane", u_if.lane, 0);
    chk("rst_valid", u_if.dout_valid, 0);
    chk("rst_serr", u_if.sync_err, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'b0, 1'b0, 1'b0);
      if (u_if.dout_valid || u_if.sync_err) pulses++;
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_dout", u_if.dout, 0);
    chk("idle_lane", u_if.lane, 0);

    // 2: single frame, lane-order bits 1,0,1,0,0,1,1,0
    send_frame(8'h65, 1'b1, 1'b0, c1);
    chk("s2_dout_raw", u_if.dout, exp_word(8'h65));
    send(1'b0, 1'b0, 1'b0);
    chk("s2_single_pulse", u_if.dout_valid, 0);
    chk("s2_hold", u_if.dout, exp_word(8'h65));

    // 3: back-to-back frames, sync only on the first
    send_frame(8'hA5, 1'b1, 1'b0, c1);
    send_frame(8'h3C, 1'b0, 1'b0, c2);
    chk("s3_spacing", c2 - c1, 8);
    send(1'b0, 1'b0, 1'b0);
    chk("s3_single_pulse", u_if.dout_valid, 0);

    // 4: gapped frame
    send_frame(8'hF0, 1'b1, 1'b1, c1);
    send(1'b0, 1'b0, 1'b0);
    chk("s4_single_pulse", u_if.dout_valid, 0);

    // 5: misaligned sync at lane 4, then frame 0x81
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 1'b1, k == 0);
      chk("s5_partial_valid", u_if.dout_valid, 0);
      chk("s5_partial_serr", u_if.sync_err, 0);
    end
    chk("s5_lane4", u_if.lane, 4);
    send(1'b1, 1'b1, 1'b1);
    chk("s5_serr", u_if.sync_err, 1);
    chk("s5_lane_after_sync", u_if.lane, 1);
    chk("s5_no_valid", u_if.dout_valid, 0);
    chk("s5_dout_kept", u_if.dout, exp_word(8'hF0));
    send(1'b0, 1'b1, 1'b0);
    chk("s5_serr_single", u_if.sync_err, 0);
    for (int k = 2; k < 8; k++) send(k == 7, 1'b1, 1'b0);
    chk("s5_valid", u_if.dout_valid, 1);
    chk("s5_dout", u_if.dout, exp_word(8'h81));

    // sync with din_valid low mid-frame
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    chk("nv_sync_serr", u_if.sync_err, 1);
    chk("nv_sync_lane", u_if.lane, 0);
    send(1'b0, 1'b0, 1'b1);
    chk("nv_sync_lane0_noerr", u_if.sync_err, 0);

    // 6: async reset at lane 5
    for (int k = 0; k < 5; k++) send(1'b1, 1'b1, k == 0);
    chk("s6_lane5", u_if.lane, 5);
    @(negedge clk);
    u_if.din_valid = 1'b0; u_if.sync = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("s6_async_lane", u_if.lane, 0);
    chk("s6_async_dout", u_if.dout, 0);
    #1 rst = 1'b0;
    send_frame(8'h7E, 1'b1, 1'b0, c1);
    chk("s6_serr", u_if.sync_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0x0 exp=0x1");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
